dma_priority_encoder: RTL and testbench
=======================================

Name: dma_priority_encoder

Overview:
- Request-side arbiter for the 8237A DMA controller.
- Collects hardware DREQ lines and software request bits, and applies mask and command-register controls.
- Selects one channel using fixed or rotating priority, then drives ValidReqID/ReqID (the PE modport of the control interface) into the timing control logic.
- Holds the grant until the timing control logic releases it, then rotates priority if rotating mode is enabled.

Parameters:
- NUM_CH, 4, number of DMA channels; the design is verified at 4 only.
- ID_W, 2, width of ReqID; equals $clog2(NUM_CH).

Ports:
- CLK  input  1  system clock; all logic is on the rising edge.
- RESET_N  input  1  synchronous active-low reset.
- DREQ  input  NUM_CH  hardware DMA request lines; polarity is set by DreqSenseLow.
- SwReq  input  NUM_CH  software request register bits; always active-high and never masked.
- Mask  input  NUM_CH  mask register; 1 blocks hardware DREQ on that channel.
- RotatePri  input  1  command bit 4; 1 = rotating priority, 0 = fixed priority (ch0 highest).
- DreqSenseLow  input  1  command bit 6; 1 = DREQ is active-low.
- CtrlDisable  input  1  command bit 2; 1 = no new grants are issued.
- MasterClear  input  1  software master clear; same effect as reset on this block.
- Release  input  1  one-cycle pulse from the timing control logic: service of the granted channel is complete.
- ValidReqID  output  1  a grant is active.
- ReqID  output  ID_W  granted channel number; valid only while ValidReqID=1.

Behaviour:
- Effective request per channel: Eff[i] = SwReq[i] | (~Mask[i] & (DREQ[i] ^ DreqSenseLow)).
- Priority pointer Top (ID_W bits) names the highest-priority channel. Priority descends Top, Top+1, ... modulo NUM_CH, wrapping 3->0.
- Fixed mode forces Top=0 for arbitration. The stored pointer is kept, but is ignored while RotatePri=0.
- FSM states:
  - IDLE: ValidReqID=0. If CtrlDisable=0 and any Eff bit is set, go to GRANT on the next edge, latching the winning channel into ReqID.
  - GRANT: ValidReqID=1 and ReqID is held stable regardless of Eff, Mask or CtrlDisable changes. On Release=1, go to WRAP.
  - WRAP: one cycle with ValidReqID=0. If RotatePri=1, Top <= ReqID+1 (mod NUM_CH). Always go to IDLE.
- Latency:
  - A request present at edge t produces ValidReqID=1 after edge t+1.
  - Minimum gap between consecutive grants is 2 idle cycles (WRAP, then IDLE).
- Boundary conditions:
  - Release while in IDLE or WRAP is ignored.
  - A request that drops during GRANT does not revoke the grant; the timing control logic owns termination.
  - Setting CtrlDisable during GRANT has no effect until Release.
  - Simultaneous Release and a new request: Release is honoured; the new request is arbitrated in IDLE.
  - Ties are impossible, because arbitration is strictly ordered by Top.
- Reset/MasterClear: go to IDLE; ValidReqID=0, ReqID=0, Top=0, synchronizer flops=0. This applies mid-grant as well. MasterClear takes priority over every other input in the same cycle.
- ReqID holds its last granted value while ValidReqID=0, except after reset, when it is 0.

Optional Feature:
- DREQ_SYNC_EN defined: each DREQ bit passes through a 2-flop synchronizer (reset to 0) before polarity and mask logic. This adds 2 cycles to hardware-request latency; SwReq is not delayed.
- DREQ_SYNC_EN undefined: DREQ is used directly. The integrator guarantees DREQ is synchronous to CLK.

Decomposition:
- dma_pkg holds:
  - typedef chan_id_t (logic [1:0]);
  - enum pe_state_t {PE_IDLE, PE_GRANT, PE_WRAP};
  - constants CMD_DISABLE_BIT=2, CMD_ROTATE_BIT=4, CMD_DREQ_SENSE_BIT=6, NUM_DMA_CH=4.
- Sub-module dma_prio_pick: purely combinational. Inputs Eff and Top; outputs Any and Winner (first set bit searching Top upward with wrap).

Test Plan:
- Fixed priority: RotatePri=0, DREQ=4'b1010 -> ValidReqID=1, ReqID=1 one cycle later; after Release, DREQ still 4'b1010 -> ReqID=1 again.
- Rotating priority: RotatePri=1, grant ch1 then Release -> Top=2; with DREQ=4'b1011 the next grant is ReqID=3, then Top=0, then ReqID=0.
- Mask, sense and software request: Mask=4'b0001 with DREQ=4'b0001 -> no grant. SwReq=4'b0001 -> grant ch0. DreqSenseLow=1 with DREQ=4'b1110 -> grant ch0.
- Grant hold: grant ch2, then drop DREQ and set CtrlDisable=1 -> ReqID stays 2 and ValidReqID stays 1 until Release. With CtrlDisable=1, no further grants.
- Reset/MasterClear mid-GRANT: with ch3 granted and Top=2, MasterClear pulse -> next cycle ValidReqID=0, ReqID=0, Top=0. Repeat the same check with RESET_N low.
- Synchronizer latency (DREQ_SYNC_EN build): DREQ[0] asserted at edge t -> ValidReqID=1 after edge t+3; SwReq[0] -> ValidReqID=1 after edge t+1.

Source files
------------

// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared types and constants for the 8237A-style DMA request-side logic.
//   chan_id_t    : channel number (2 bits for a 4-channel controller)
//   pe_state_t   : priority-encoder FSM states
//   CMD_*_BIT    : command-register bit positions driving RotatePri,
//                  DreqSenseLow and CtrlDisable
//   NUM_DMA_CH   : number of DMA channels
// Helper function next_chan() returns the channel after a given one, wrapping
// at NUM_DMA_CH.
// -----------------------------------------------------------------------------
package dma_pkg;

    localparam int NUM_DMA_CH         = 4;
    localparam int CMD_DISABLE_BIT    = 2;
    localparam int CMD_ROTATE_BIT     = 4;
    localparam int CMD_DREQ_SENSE_BIT = 6;

    typedef logic [1:0] chan_id_t;

    typedef enum logic [1:0] {
        PE_IDLE  = 2'd0,
        PE_GRANT = 2'd1,
        PE_WRAP  = 2'd2
    } pe_state_t;

    // Channel following ch, modulo NUM_DMA_CH.
    function automatic chan_id_t next_chan(input chan_id_t ch);
        next_chan = chan_id_t'((int'(ch) + 1) % NUM_DMA_CH);
    endfunction

endpackage

// File: rtl/dma_prio_pick.sv
// -----------------------------------------------------------------------------
// dma_prio_pick
// Purely combinational priority picker. Searches the effective request vector
// starting at channel Top and moving upward with wrap-around. The first set bit
// found is the winner.
// Ports:
//   Eff    [NUM_CH-1:0] in  : effective request per channel
//   Top    [ID_W-1:0]   in  : highest-priority channel for this arbitration
//   Any                 out : at least one request is set
//   Winner [ID_W-1:0]   out : winning channel (0 when Any=0)
// -----------------------------------------------------------------------------
module dma_prio_pick #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = 2
) (
    input  logic [NUM_CH-1:0] Eff,
    input  logic [ID_W-1:0]   Top,
    output logic              Any,
    output logic [ID_W-1:0]   Winner
);

    logic [ID_W-1:0] idx;

    always_comb begin
        Any    = |Eff;
        Winner = '0;
        idx    = '0;
        // Walk from lowest priority to highest so that the last assignment,
        // i.e. the one closest to Top, wins.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = ID_W'((int'(Top) + k) % NUM_CH);
            if (Eff[idx]) begin
                Winner = idx;
            end
        end
    end

endmodule

// File: rtl/dma_priority_encoder.sv
// -----------------------------------------------------------------------------
// dma_priority_encoder
// Request-side arbiter for an 8237A-style DMA controller. Combines hardware
// DREQ lines (polarity- and mask-qualified) with software request bits, picks
// one channel by fixed or rotating priority and holds the grant
// (ValidReqID/ReqID) until the timing control logic pulses Release.
//
// Build option: define DREQ_SYNC_EN to pass each DREQ bit through a 2-flop
// synchronizer before the polarity/mask logic (adds 2 cycles of hardware
// request latency; SwReq is not delayed). Without it DREQ must already be
// synchronous to CLK.
//
// Handshake: ValidReqID rises one edge after a qualifying request is seen in
// IDLE and stays high with ReqID frozen until Release=1 is sampled in GRANT.
// Release at any other time is ignored. After a grant there is always one WRAP
// cycle and one IDLE cycle with ValidReqID=0 before the next grant.
//
// Ports:
//   CLK, RESET_N          : clock, synchronous active-low reset
//   DREQ      [NUM_CH]    : hardware requests (polarity set by DreqSenseLow)
//   SwReq     [NUM_CH]    : software requests, active-high, never masked
//   Mask      [NUM_CH]    : 1 blocks hardware DREQ on that channel
//   RotatePri             : 1 = rotating priority, 0 = fixed (ch0 highest)
//   DreqSenseLow          : 1 = DREQ active-low
//   CtrlDisable           : 1 = no new grants
//   MasterClear           : same effect as reset, overrides all inputs
//   Release               : grant service complete (one-cycle pulse)
//   ValidReqID, ReqID     : grant valid, granted channel
//   DbgState, DbgTop      : FSM state and stored priority pointer (debug)
// -----------------------------------------------------------------------------
module dma_priority_encoder
    import dma_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ID_W   = 2
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] SwReq,
    input  logic [NUM_CH-1:0] Mask,
    input  logic              RotatePri,
    input  logic              DreqSenseLow,
    input  logic              CtrlDisable,
    input  logic              MasterClear,
    input  logic              Release,
    output logic              ValidReqID,
    output logic [ID_W-1:0]   ReqID,
    output pe_state_t         DbgState,
    output logic [ID_W-1:0]   DbgTop
);

    logic              clear;
    logic [NUM_CH-1:0] dreq_s;
    logic [NUM_CH-1:0] eff;
    logic [ID_W-1:0]   arb_top;
    logic              any;
    logic [ID_W-1:0]   winner;

    pe_state_t         state;
    logic              valid_q;
    logic [ID_W-1:0]   req_id_q;
    logic [ID_W-1:0]   top_q;

    // MasterClear behaves exactly like reset and wins over everything else.
    assign clear = !RESET_N || MasterClear;

`ifdef DREQ_SYNC_EN
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;

    always_ff @(posedge CLK) begin
        if (clear) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= DREQ;
            sync2 <= sync1;
        end
    end

    assign dreq_s = sync2;
`else
    assign dreq_s = DREQ;
`endif

    assign eff = SwReq | (~Mask & (dreq_s ^ {NUM_CH{DreqSenseLow}}));

    // Fixed mode arbitrates from ch0; the stored pointer is left untouched.
    assign arb_top = RotatePri ? top_q : '0;

    dma_prio_pick #(
        .NUM_CH (NUM_CH),
        .ID_W   (ID_W)
    ) u_pick (
        .Eff    (eff),
        .Top    (arb_top),
        .Any    (any),
        .Winner (winner)
    );

    always_ff @(posedge CLK) begin
        if (clear) begin
            state    <= PE_IDLE;
            valid_q  <= 1'b0;
            req_id_q <= '0;
            top_q    <= '0;
        end else begin
            case (state)
                PE_IDLE: begin
                    if (!CtrlDisable && any) begin
                        state    <= PE_GRANT;
                        valid_q  <= 1'b1;
                        req_id_q <= winner;
                    end
                end
                PE_GRANT: begin
                    // Grant is held regardless of request, mask or disable
                    // changes; only Release ends it.
                    if (Release) begin
                        state   <= PE_WRAP;
                        valid_q <= 1'b0;
                    end
                end
                PE_WRAP: begin
                    if (RotatePri) begin
                        top_q <= ID_W'((int'(req_id_q) + 1) % NUM_CH);
                    end
                    state <= PE_IDLE;
                end
                default: begin
                    state   <= PE_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ValidReqID = valid_q;
    assign ReqID      = req_id_q;
    assign DbgState   = state;
    assign DbgTop     = top_q;

endmodule

// File: tb/tb_dma_priority_encoder.sv
// -----------------------------------------------------------------------------
// tb_dma_priority_encoder
// Directed testbench for dma_priority_encoder. Expected grant channels are
// pushed into exp_q as requests are driven; a monitor pops one entry on every
// rising edge of ValidReqID and compares it with ReqID. Timing, hold and
// reset behaviour are checked inline by the driver.
// -----------------------------------------------------------------------------
module tb_dma_priority_encoder;
    import dma_pkg::*;

    localparam int NUM_CH = 4;
    localparam int ID_W   = 2;
`ifdef DREQ_SYNC_EN
    localparam int HW_LAT = 3;
`else
    localparam int HW_LAT = 1;
`endif

    logic              CLK;
    logic              RESET_N;
    logic [NUM_CH-1:0] DREQ;
    logic [NUM_CH-1:0] SwReq;
    logic [NUM_CH-1:0] Mask;
    logic              RotatePri;
    logic              DreqSenseLow;
    logic              CtrlDisable;
    logic              MasterClear;
    logic              Release;
    logic              ValidReqID;
    logic [ID_W-1:0]   ReqID;
    pe_state_t         DbgState;
    logic [ID_W-1:0]   DbgTop;

    logic [ID_W-1:0]   exp_q[$];
    int                n_checks = 0;
    int                n_pass   = 0;
    logic              prev_valid = 1'b0;

    dma_priority_encoder #(.NUM_CH(NUM_CH), .ID_W(ID_W)) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .DREQ         (DREQ),
        .SwReq        (SwReq),
        .Mask         (Mask),
        .RotatePri    (RotatePri),
        .DreqSenseLow (DreqSenseLow),
        .CtrlDisable  (CtrlDisable),
        .MasterClear  (MasterClear),
        .Release      (Release),
        .ValidReqID   (ValidReqID),
        .ReqID        (ReqID),
        .DbgState     (DbgState),
        .DbgTop       (DbgTop)
    );

    // Clock / watchdog
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard monitor: one expected channel per new grant.
    always @(negedge CLK) begin
        if (ValidReqID && !prev_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_grant: got ReqID=%0d expected no grant (t=%0t)",
                         ReqID, $time);
            end else begin
                check("grant_id", int'(ReqID), int'(exp_q.pop_front()));
            end
        end
        prev_valid = ValidReqID;
    end

    // Driver tasks
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_grant_after(input int lat);
        for (int i = 0; i < lat - 1; i++) begin
            cyc();
            check("pre_grant_valid", int'(ValidReqID), 0);
        end
        cyc();
        check("grant_valid", int'(ValidReqID), 1);
    endtask

    // From GRANT: Release edge -> WRAP, next edge -> IDLE.
    task automatic release_to_idle();
        Release = 1'b1;
        cyc();
        check("release_drop_valid", int'(ValidReqID), 0);
        Release = 1'b0;
        cyc();
        check("idle_gap_valid", int'(ValidReqID), 0);
    endtask

    initial begin
        RESET_N      = 1'b0;
        DREQ         = '0;
        SwReq        = '0;
        Mask         = '0;
        RotatePri    = 1'b0;
        DreqSenseLow = 1'b0;
        CtrlDisable  = 1'b0;
        MasterClear  = 1'b0;
        Release      = 1'b0;
        cyc();
        cyc();
        check("reset_valid", int'(ValidReqID), 0);
        check("reset_reqid", int'(ReqID), 0);
        check("reset_top", int'(DbgTop), 0);
        check("reset_state", int'(DbgState), int'(PE_IDLE));
        RESET_N = 1'b1;
        cyc();

        // Fixed priority: 1010 -> ch1, and ch1 again after release.
        DREQ = 4'b1010;
        exp_q.push_back(2'd1);
        expect_grant_after(HW_LAT);
        release_to_idle();
        exp_q.push_back(2'd1);
        expect_grant_after(1);
        check("fixed_top_unchanged", int'(DbgTop), 0);

        // Rotating priority: ch1, then Top=2 -> ch3, then Top=0 -> ch0.
        DREQ = 4'b0000;
        release_to_idle();
        RotatePri = 1'b1;
        DREQ = 4'b0010;
        exp_q.push_back(2'd1);
        expect_grant_after(HW_LAT);
        DREQ = 4'b1011;
        release_to_idle();
        check("rot_top_after_ch1", int'(DbgTop), 2);
        exp_q.push_back(2'd3);
        expect_grant_after(1);
        release_to_idle();
        check("rot_top_after_ch3", int'(DbgTop), 0);
        exp_q.push_back(2'd0);
        expect_grant_after(1);
        DREQ = 4'b0000;
        release_to_idle();
        check("rot_top_after_ch0", int'(DbgTop), 1);

        // Mask blocks DREQ; SwReq is never masked.
        RotatePri = 1'b0;
        Mask = 4'b0001;
        DREQ = 4'b0001;
        repeat (4) cyc();
        check("mask_blocks_valid", int'(ValidReqID), 0);
        SwReq = 4'b0001;
        exp_q.push_back(2'd0);
        expect_grant_after(1);
        // Reconfigure while granted: grant is held, new setup seen in IDLE.
        SwReq = 4'b0000;
        Mask = 4'b0000;
        DreqSenseLow = 1'b1;
        DREQ = 4'b1110;
        check("hold_despite_input_change", int'(ValidReqID), 1);
        release_to_idle();
        exp_q.push_back(2'd0);
        expect_grant_after(1);

        // Grant hold: ch2 survives request drop and CtrlDisable.
        DreqSenseLow = 1'b0;
        DREQ = 4'b0100;
        release_to_idle();
        exp_q.push_back(2'd2);
        expect_grant_after(1);
        DREQ = 4'b0000;
        CtrlDisable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("hold_valid", int'(ValidReqID), 1);
            check("hold_reqid", int'(ReqID), 2);
        end
        release_to_idle();
        DREQ = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("disabled_no_grant", int'(ValidReqID), 0);
        end
        check("reqid_held_idle", int'(ReqID), 2);
        DREQ = 4'b0010;
        repeat (3) cyc();
        check("disabled_no_grant2", int'(ValidReqID), 0);

        // MasterClear mid-grant with ch3 granted and Top=2.
        CtrlDisable = 1'b0;
        RotatePri = 1'b1;
        exp_q.push_back(2'd1);
        expect_grant_after(1);
        DREQ = 4'b1000;
        release_to_idle();
        check("mc_setup_top", int'(DbgTop), 2);
        exp_q.push_back(2'd3);
        expect_grant_after(1);
        MasterClear = 1'b1;
        Release = 1'b1;
        DREQ = 4'b0000;
        cyc();
        MasterClear = 1'b0;
        Release = 1'b0;
        check("mc_valid", int'(ValidReqID), 0);
        check("mc_reqid", int'(ReqID), 0);
        check("mc_top", int'(DbgTop), 0);
        check("mc_state", int'(DbgState), int'(PE_IDLE));
        repeat (3) cyc();
        check("mc_stays_idle", int'(ValidReqID), 0);

        // Same scenario with RESET_N.
        DREQ = 4'b0010;
        exp_q.push_back(2'd1);
        expect_grant_after(HW_LAT);
        DREQ = 4'b1000;
        release_to_idle();
        check("rst_setup_top", int'(DbgTop), 2);
        exp_q.push_back(2'd3);
        expect_grant_after(1);
        RESET_N = 1'b0;
        DREQ = 4'b0000;
        cyc();
        RESET_N = 1'b1;
        check("rst_valid", int'(ValidReqID), 0);
        check("rst_reqid", int'(ReqID), 0);
        check("rst_top", int'(DbgTop), 0);
        check("rst_state", int'(DbgState), int'(PE_IDLE));
        cyc();

        // SwReq latency is one edge in every build.
        SwReq = 4'b0001;
        exp_q.push_back(2'd0);
        expect_grant_after(1);
        SwReq = 4'b0000;
        release_to_idle();
        repeat (2) cyc();

        // Hardware request latency from a quiet start.
        DREQ = 4'b0001;
        exp_q.push_back(2'd0);
        expect_grant_after(HW_LAT);
        DREQ = 4'b0000;
        release_to_idle();
        repeat (2) cyc();

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
